// File: rtl/demux8_router_pkg.sv
// Shared definitions for the eight-channel single-entry demux router.
package demux8_router_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned NUM_CHANNELS = 8;
    localparam int unsigned COUNT_WIDTH  = 32;

endpackage : demux8_router_pkg

// File: rtl/demux8_router_decode.sv
// One-hot channel decoder; all outputs are forced low when the enable is low.
module demux8_decode
    import demux8_router_pkg::*;
#(
    parameter int SELECT_SIZE = 3
) (
    input  logic                    en,
    input  logic [SELECT_SIZE-1:0]  sel,
    output logic [NUM_CHANNELS-1:0] onehot
);

    // Select values beyond the last channel decode to no channel at all.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            onehot[i] = en && (sel == SELECT_SIZE'(i));
        end
    end

endmodule : demux8_decode

// File: rtl/demux8_router.sv
// Single-entry buffer that routes each upstream word to one of eight
// downstream channels and counts delivered words.
module demux8_router
    import demux8_router_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SELECT_SIZE = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [SELECT_SIZE-1:0]  select_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic [NUM_CHANNELS-1:0] valid_o,
    input  logic [NUM_CHANNELS-1:0] ready_i,
    output logic [COUNT_WIDTH-1:0]  xfer_count_o
);

    state_e                  state_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [SELECT_SIZE-1:0]  sel_r;
    logic [COUNT_WIDTH-1:0]  xfer_count_r;
    logic [NUM_CHANNELS-1:0] chan_valid_s;
    logic                    deliver_s;
    logic                    accept_s;
    logic                    ready_s;

    demux8_decode #(
        .SELECT_SIZE (SELECT_SIZE)
    ) u_decode (
        .en     (state_r == ST_FULL),
        .sel    (sel_r),
        .onehot (chan_valid_s)
    );

    // Masking ready_i with the one-hot valid ignores every non-selected
    // channel, and ready_o never depends on valid_i.
    always_comb begin
        deliver_s = |(ready_i & chan_valid_s);
        ready_s   = (state_r == ST_EMPTY) || deliver_s;
        accept_s  = valid_i && ready_s;
    end

    // Buffer state, captured word/select and delivery counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= ST_EMPTY;
            data_r       <= '0;
            sel_r        <= '0;
            xfer_count_r <= '0;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_r <= ST_FULL;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deliver_s && !accept_s) begin
                        state_r <= ST_EMPTY;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                end
            endcase
            if (accept_s) begin
                data_r <= data_i;
                sel_r  <= select_i;
            end
            if (deliver_s) begin
                xfer_count_r <= xfer_count_r + COUNT_WIDTH'(1);
            end
        end
    end

    assign ready_o      = ready_s;
    assign valid_o      = chan_valid_s;
    assign data_o       = data_r;
    assign xfer_count_o = xfer_count_r;

endmodule : demux8_router

// File: doc/demux8_router.md
DEMUX8_ROUTER -- requirements
Module: demux8_router

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of routed data word.
REQ-002 SHALL have parameter SELECT_SIZE, default 3, width of channel select (8 channels).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  upstream word present.
REQ-006 SHALL have port ready_o  output  1  block accepts upstream word this cycle.
REQ-007 SHALL have port select_i  input  SELECT_SIZE  destination channel of upstream word.
REQ-008 SHALL have port data_i  input  DATA_WIDTH  upstream word.
REQ-009 SHALL have port data_o  output  DATA_WIDTH  held word, shared by all channels.
REQ-010 SHALL have port valid_o  output  8  one-hot per-channel valid of held word.
REQ-011 SHALL have port ready_i  input  8  per-channel downstream ready.
REQ-012 SHALL have port xfer_count_o  output  32  count of words delivered downstream.

Function
REQ-013 SHALL implement a single-entry buffer with FSM states EMPTY and FULL.
REQ-014 SHALL accept an upstream word when valid_i and ready_o are both 1 at a clock edge (transfer).
REQ-015 SHALL drive ready_o = 1 in EMPTY; in FULL, ready_o = ready_i[sel_q] (combinational pass-through), where sel_q is the captured select.
REQ-016 SHALL, on accept, capture data_i into data_o and select_i into sel_q; the captured word appears on outputs the next cycle (latency 1).
REQ-017 SHALL drive valid_o = one-hot(sel_q) in FULL and 8'h00 in EMPTY; never more than one bit set.
REQ-018 SHALL deliver a word when FULL and ready_i[sel_q] = 1 at a clock edge; ready_i bits of non-selected channels are ignored.
REQ-019 SHALL transition EMPTY -> FULL on accept; EMPTY stays EMPTY otherwise.
REQ-020 SHALL transition FULL -> EMPTY on delivery with no accept; FULL -> FULL on delivery with simultaneous accept (new word replaces, no bubble); FULL holds otherwise.
REQ-021 SHALL keep data_o, sel_q and valid_o stable while FULL and not delivered.
REQ-022 SHALL retain last data_o value in EMPTY (no clearing on delivery).
REQ-023 SHALL sustain one word per cycle when the addressed channel is continuously ready.
REQ-024 SHALL increment xfer_count_o by exactly 1 per delivery, wrapping 32'hFFFF_FFFF -> 0.
REQ-025 SHALL never drop or duplicate a word: each accepted word is delivered exactly once unless reset intervenes.

Reset
REQ-026 SHALL, when reset_i = 1 at a clock edge, enter EMPTY, set data_o = 0, sel_q = 0, valid_o = 8'h00, xfer_count_o = 0.
REQ-027 SHALL, on reset mid-operation, discard the held word without delivery and not count it.
REQ-028 SHALL ignore valid_i and ready_i during a reset cycle (no accept, no delivery, no count).
REQ-029 SHALL drive ready_o = 1 in the first cycle after reset deasserts.

Structure
REQ-030 SHALL place the state enum (EMPTY, FULL), the channel count constant (8) and the counter width constant (32) in the shared project package.
REQ-031 SHALL instantiate one sub-module, demux8_decode, a combinational SELECT_SIZE-to-8 one-hot decoder gated by an enable (FULL).
REQ-032 SHALL contain no latches and no combinational path from valid_i to ready_o.

Verification
REQ-033 Reset then valid_i=1, select_i=5, data_i=32'hDEAD_BEEF, ready_i=8'h20 -> next cycle valid_o=8'h20, data_o=32'hDEAD_BEEF; following cycle valid_o=0, xfer_count_o=1.
REQ-034 Hold: word to select 2, ready_i=8'hFB for 4 cycles -> valid_o=8'h04 and data_o stable 4 cycles, ready_o=0; ready_i[2]=1 -> delivered, count +1.
REQ-035 Back-to-back: 8 words, select 0..7, data 1..8, ready_i=8'hFF -> valid_o walks 8'h01..8'h80 on consecutive cycles, no bubbles, count=8.
REQ-036 Wrong-channel ready: word to select 7, ready_i=8'h7F -> held indefinitely, count unchanged.
REQ-037 Reset mid-operation: FULL with select 3 unready, assert reset_i 1 cycle -> valid_o=0, count=0, ready_o=1 after; held word never appears.
REQ-038 Counter wrap: force count to 32'hFFFF_FFFF, deliver one word -> xfer_count_o=0.
